// File: rtl/bp_sacc_coh_flit_tx.sv
// Serializes one coherence message (header + 0..data_flits_max_p words) into wormhole flits on a ready&valid link.
// Optional BP_SACC_FLIT_TX_OVERLAP_EN: accept the next message during the final flit for zero-bubble back-to-back.
module bp_sacc_coh_flit_tx #(
    parameter int flit_width_p     = 64,
    parameter int cord_width_p     = 7,
    parameter int len_width_p      = 4,
    parameter int hdr_width_p      = 53,
    parameter int data_flits_max_p = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [cord_width_p-1:0]                  dst_cord_i,
    input  logic [hdr_width_p-1:0]                   hdr_i,
    input  logic [data_flits_max_p*flit_width_p-1:0] data_i,
    input  logic [len_width_p-1:0]                   data_flits_i,
    input  logic                                     v_i,
    output logic                                     ready_and_o,
    output logic [flit_width_p-1:0]                  link_data_o,
    output logic                                     link_v_o,
    input  logic                                     link_ready_and_i,
    output logic                                     busy_o,
    output logic                                     err_len_o
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

    localparam logic [len_width_p-1:0] MaxLen = len_width_p'(data_flits_max_p);
    localparam logic [len_width_p-1:0] One    = len_width_p'(1);

    state_e                                 state_q, state_d;
    logic [len_width_p-1:0]                 cnt_q, cnt_d, cnt_inc;
    logic                                   err_q, err_d;
    logic [cord_width_p-1:0]                cord_q;
    logic [hdr_width_p-1:0]                 hdr_q;
    logic [len_width_p-1:0]                 len_q;
    logic [data_flits_max_p*flit_width_p-1:0] data_q;

    logic                                   accept, len_ok, link_hs, last_flit;
    logic [flit_width_p-1:0]                word_sel;

    assign accept    = v_i & ready_and_o;
    assign len_ok    = (data_flits_i <= MaxLen);
    assign link_hs   = link_v_o & link_ready_and_i;
    assign cnt_inc   = cnt_q + One;
    assign last_flit = ((state_q == HDR) && (len_q == '0)) ||
                       ((state_q == DATA) && (cnt_inc == len_q));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Message payload is only sampled on accept; no reset needed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            cord_q <= dst_cord_i;
            hdr_q  <= hdr_i;
            len_q  <= data_flits_i;
            data_q <= data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (accept & ~len_ok);
        case (state_q)
            IDLE: begin
                if (accept && len_ok) state_d = HDR;
            end
            HDR: begin
                if (link_hs) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (link_hs) begin
                    if (cnt_inc == len_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BP_SACC_FLIT_TX_OVERLAP_EN
        if (last_flit && link_hs && accept && len_ok) begin
            state_d = HDR;
        end
`endif
    end

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < data_flits_max_p; k++) begin
            if (cnt_q == len_width_p'(k)) word_sel = data_q[k*flit_width_p +: flit_width_p];
        end
    end

    always_comb begin
`ifdef BP_SACC_FLIT_TX_OVERLAP_EN
        ready_and_o = (state_q == IDLE) | (last_flit & link_ready_and_i);
`else
        ready_and_o = (state_q == IDLE);
`endif
        link_v_o    = (state_q != IDLE);
        busy_o      = (state_q != IDLE);
        err_len_o   = err_q;
        case (state_q)
            HDR:     link_data_o = {hdr_q, len_q, cord_q};
            DATA:    link_data_o = word_sel;
            default: link_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_bp_sacc_coh_flit_tx.sv
// Scoreboard bench for bp_sacc_coh_flit_tx: directed messages, expected flits queued, monitor checks handshakes.
module tb_bp_sacc_coh_flit_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [6:0]   cord;
    logic [52:0]  hdr;
    logic [511:0] data;
    logic [3:0]   len;
    logic         v;
    logic         rdy_o;
    logic [63:0]  link_data;
    logic         link_v;
    logic         link_rdy = 1'b1;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_hs = 0;
    int n_stall = 0;
    bit toggle_en = 1'b0;
    logic [63:0] exp_q[$];
    int got_cyc[$];

    bp_sacc_coh_flit_tx dut (
        .clk_i           (clk),
        .reset_n_i       (rst_n),
        .dst_cord_i      (cord),
        .hdr_i           (hdr),
        .data_i          (data),
        .data_flits_i    (len),
        .v_i             (v),
        .ready_and_o     (rdy_o),
        .link_data_o     (link_data),
        .link_v_o        (link_v),
        .link_ready_and_i(link_rdy),
        .busy_o          (busy),
        .err_len_o       (err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Link ready: always 1 unless toggling is enabled.
    initial forever begin
        @(posedge clk); #1;
        link_rdy = toggle_en ? ~link_rdy : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Monitor: compares each link handshake against the scoreboard, and checks stall stability.
    initial begin
        logic        stall_prev;
        logic [63:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", {63'd0, link_v}, 64'd1);
                    chk("hold_data", link_data, stall_data);
                end
                if (link_v && link_rdy) begin
                    n_hs++;
                    got_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_flit: got %h expected none", link_data);
                    end else begin
                        chk("flit", link_data, exp_q.pop_front());
                    end
                end
                if (link_v && !link_rdy) n_stall++;
                stall_prev = link_v && !link_rdy;
                stall_data = link_data;
            end
        end
    end

    task automatic push_msg(input logic [6:0] c, input logic [52:0] h, input logic [511:0] d,
                            input logic [3:0] l, input int nwords);
        exp_q.push_back({h, l, c});
        for (int k = 0; k < nwords; k++) exp_q.push_back(d[k*64 +: 64]);
    endtask

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input logic [6:0] c, input logic [52:0] h, input logic [511:0] d, input logic [3:0] l);
        int t = 0;
        cord = c; hdr = h; data = d; len = l; v = 1'b1;
        @(negedge clk);
        while (!rdy_o && t < 200) begin @(negedge clk); t++; end
        if (!rdy_o) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got ready 0 expected 1");
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        v = 1'b0; cord = '1; hdr = '1; data = ~d; len = 4'hF;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 300) begin @(posedge clk); #1; t++; end
        chk(name, {63'd0, (exp_q.size() == 0 && busy === 1'b0)}, 64'd1);
    endtask

    initial begin
        logic [511:0] d;
        int base, t;
        rst_n = 1'b0; v = 1'b0; cord = '0; hdr = '0; data = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_link_v", {63'd0, link_v}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {63'd0, rdy_o}, 64'd1);

        // 1: header-only message
        got_cyc.delete();
        exp_q.push_back(64'h0000_0000_091A_2805);
        send(7'h05, 53'h1_2345, '0, 4'd0);
        chk("t1_busy_hdr", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        chk("t1_busy_after", {63'd0, busy}, 64'd0);
        chk("t1_nflits", got_cyc.size(), 1);
        chk("t1_latency", got_cyc[0], acc_cyc);
        wait_done("t1_done");

        // 2: three data words back-to-back
        got_cyc.delete();
        d = '0;
        d[63:0] = 64'hAAAA_0000_1111_0001; d[127:64] = 64'hBBBB_0000_2222_0002; d[191:128] = 64'hCCCC_0000_3333_0003;
        push_msg(7'h12, 53'h0_ABCD_EF01, d, 4'd3, 3);
        send(7'h12, 53'h0_ABCD_EF01, d, 4'd3);
        wait_done("t2_done");
        chk("t2_nflits", got_cyc.size(), 4);
        chk("t2_first", got_cyc[0], acc_cyc);
        chk("t2_span", got_cyc[3] - got_cyc[0], 3);

        // 3: link ready toggling
        got_cyc.delete();
        n_stall = 0;
        d = '0; d[63:0] = 64'hDEAD_BEEF_0000_0010; d[127:64] = 64'h0123_4567_89AB_CDEF;
        toggle_en = 1'b1;
        push_msg(7'h7F, 53'h1F_FFFF_0000_0001, d, 4'd2, 2);
        send(7'h7F, 53'h1F_FFFF_0000_0001, d, 4'd2);
        wait_done("t3_done");
        toggle_en = 1'b0;
        @(posedge clk); #1;
        chk("t3_nflits", got_cyc.size(), 3);
        chk("t3_stalled", {63'd0, (n_stall > 0)}, 64'd1);

        // 4: illegal length is dropped and flagged
        got_cyc.delete();
        send(7'h01, 53'h5, '1, 4'd9);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_err", {63'd0, err}, 64'd1);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_noflit", got_cyc.size(), 0);
        d = '0; d[63:0] = 64'h5555_6666_7777_8888;
        push_msg(7'h22, 53'h33, d, 4'd1, 1);
        send(7'h22, 53'h33, d, 4'd1);
        wait_done("t4_done");
        chk("t4_err_sticky", {63'd0, err}, 64'd1);

        // 5: reset in the middle of a message
        d = '0;
        for (int k = 0; k < 4; k++) d[k*64 +: 64] = 64'h1000_0000_0000_0000 + 64'(k);
        base = n_hs;
        push_msg(7'h0A, 53'h77, d, 4'd4, 1);
        send(7'h0A, 53'h77, d, 4'd4);
        t = 0;
        while (n_hs < base + 2 && t < 100) begin @(posedge clk); #1; t++; end
        chk("t5_w1_shown", link_data, 64'h1000_0000_0000_0001);
        rst_n = 1'b0;
        #1;
        chk("t5_link_v", {63'd0, link_v}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_err_cleared", {63'd0, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_hs_count", n_hs - base, 2);
        chk("t5_queue_empty", exp_q.size(), 0);

        // 6: two single-word messages back-to-back
        got_cyc.delete();
        d = '0; d[63:0] = 64'hF00D_0000_0000_0001;
        push_msg(7'h03, 53'h100, d, 4'd1, 1);
        send(7'h03, 53'h100, d, 4'd1);
        d[63:0] = 64'hF00D_0000_0000_0002;
        push_msg(7'h04, 53'h200, d, 4'd1, 1);
        send(7'h04, 53'h200, d, 4'd1);
        wait_done("t6_done");
        chk("t6_nflits", got_cyc.size(), 4);
`ifdef BP_SACC_FLIT_TX_OVERLAP_EN
        chk("t6_span", got_cyc[3] - got_cyc[0], 3);
`else
        chk("t6_span", got_cyc[3] - got_cyc[0], 4);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
